// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  // One buffered writeback: destination register and the value to write.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  // One-hot register mask; register 0 is hardwired and never marked pending.
  function automatic logic [31:0] onehot32(input logic [WB_AW-1:0] addr);
    logic [31:0] m;
    m    = 32'd1 << addr;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback FIFO with an explicit occupancy counter and a per-slot
// valid view so the parent can build the pending-write mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers, slot valid bits and occupancy; pointers wrap naturally (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_do_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are qualified by r_vld so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Head presented combinationally, zero when nothing is buffered.
  always_comb begin
    head = '0;
    if (!empty) head = r_mem[r_rd_ptr];
  end

  assign entries     = r_mem;
  assign entry_valid = r_vld;
  assign count       = r_count;

endmodule

// File: rtl/wb_write_arbiter.sv
// Writer side of the register file write port. Merges ALU and load-unit
// writebacks (load has fixed priority), buffers them in order, and drains
// one write per cycle. Exports a pending-write mask for hazard logic.
// Optional macro WB_BYPASS_EN: zero-latency write when the FIFO is empty
// and the port is not stalled.
//
// Handshake: a request transfers on a rising edge where valid && ready.
// ready depends only on registered occupancy (and mem_valid for the ALU),
// never on the same-cycle pop, so there is no ready->reg_we path.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,  // must match the package entry type
  parameter int DW    = WB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  input  logic                     wb_stall,
  output logic [AW-1:0]            reg_W_addr,
  output logic [DW-1:0]            wdata,
  output logic                     reg_we,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             w_space;
  logic             w_sel_mem;
  logic             w_sel_alu;
  logic [AW-1:0]    w_req_addr;
  logic [DW-1:0]    w_req_data;
  logic             w_accept;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  wb_entry_t        w_din;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_entry_valid;

  // Space is decided from registered occupancy only; both ready low in reset.
  assign w_space   = (w_count < CW'(DEPTH));
  assign mem_ready = rst && w_space;
  assign alu_ready = rst && w_space && !mem_valid;

  assign w_sel_mem = mem_valid && mem_ready;
  assign w_sel_alu = alu_valid && alu_ready;

  // Select the winning request payload (load unit first).
  always_comb begin
    w_req_addr = alu_addr;
    w_req_data = alu_data;
    if (w_sel_mem) begin
      w_req_addr = mem_addr;
      w_req_data = mem_data;
    end
  end

  // Writes to register 0 are handshaken but dropped.
  assign w_accept = (w_sel_mem || w_sel_alu) && (w_req_addr != '0);

`ifdef WB_BYPASS_EN
  assign w_bypass = w_accept && w_empty && !wb_stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push     = w_accept && !w_bypass;
  assign w_pop      = !w_empty && !wb_stall;
  assign w_din.addr = w_req_addr;
  assign w_din.data = w_req_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (w_push),
    .din         (w_din),
    .pop         (w_pop),
    .head        (w_head),
    .full        (w_full),
    .empty       (w_empty),
    .count       (w_count),
    .entries     (w_entries),
    .entry_valid (w_entry_valid)
  );

  // Drive the write port from the bypassed request or the FIFO head.
  always_comb begin
    reg_W_addr = '0;
    wdata      = '0;
    if (w_bypass) begin
      reg_W_addr = w_req_addr;
      wdata      = w_req_data;
    end else if (w_pop) begin
      reg_W_addr = w_head.addr;
      wdata      = w_head.data;
    end
  end

  assign reg_we = w_pop || w_bypass;

  // Pending mask: OR of one-hot destinations over all occupied slots.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i]) pending_mask = pending_mask | onehot32(w_entries[i].addr);
    end
  end

  assign fifo_count = w_count;

  // w_full is implied by w_space; kept visible for checker binding.
  logic w_unused_full;
  assign w_unused_full = w_full;

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the CPU register file's single write port (reg_W_addr / wdata / reg_we).
- Accepts writeback requests from two producers, the ALU and the load unit, over valid/ready handshakes, and buffers them in a small in-order FIFO.
- Drains the FIFO onto the register file write port, one write per cycle.
- Exports a pending-write mask for the hazard/stall logic.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle when alu_valid also high
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle when mem_valid also high
mem_addr  in  AW  load destination register
mem_data  in  DW  load data
wb_stall  in  1  hold the write port idle; no dequeue while high
reg_W_addr  out  AW  register file write address
wdata  out  DW  register file write data
reg_we  out  1  register file write enable
pending_mask  out  32  bit i high while any FIFO entry targets register i
fifo_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied and pointers cleared.
  - reg_we=0, reg_W_addr=0, wdata=0, pending_mask=0, fifo_count=0.
  - alu_ready=0 and mem_ready=0 while rst is low.
  - Reset mid-operation discards all buffered entries; none of them is written.
- Ready rules (combinational):
  - space = (fifo_count < DEPTH).
  - mem_ready = space.
  - alu_ready = space && !mem_valid, so the load unit has fixed priority.
  - A request with addr==0 is accepted (ready follows the same rule) but is not enqueued.
- Enqueue:
  - At most one entry per clock edge.
  - Entry {addr, data} is written at the tail when valid && ready && addr!=0.
- Dequeue:
  - reg_we = !empty && !wb_stall.
  - reg_W_addr and wdata present the head entry combinationally; they are 0 when empty.
  - The head pops on every edge where reg_we=1.
- Latency: a request accepted at edge N into an empty, unstalled FIFO appears on the write port during cycle N..N+1 and is written at edge N+1.
- Simultaneous events:
  - Push and pop on the same edge leave the count unchanged.
  - When full, the ready outputs stay low even if a pop occurs that cycle. This is a registered-space decision and avoids a ready->reg_we path.
- Ordering: strictly FIFO. Two writes to the same register land in acceptance order.
- Pointers: wrap modulo DEPTH; occupancy is tracked by an explicit counter.
- pending_mask:
  - OR over all valid entries of the one-hot address.
  - Bit 0 is always 0.
  - Updates in the same cycle as fifo_count.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty and wb_stall=0, an accepted request with nonzero addr drives reg_W_addr/wdata/reg_we in the same cycle (zero latency) and is not enqueued. mem still has priority.
- Undefined: every write goes through the FIFO, with one cycle of minimum latency.

Decomposition:
- Package wb_pkg:
  - AW/DW default constants.
  - typedef wb_entry_t {addr[AW-1:0], data[DW-1:0]}.
  - Function onehot32(addr) for pending_mask.
- One sub-module, wb_fifo: parameterised DEPTH, with push/pop/full/empty/count and an entry-array view for mask generation.
- Arbitration, ready logic and bypass stay in the top level.

Test Plan:
- Reset, then alu_valid=1, addr=5, data=0xDEADBEEF → alu_ready=1; next cycle reg_we=1, reg_W_addr=5, wdata=0xDEADBEEF; pending_mask=0x20 for exactly one cycle.
- alu and mem both valid (alu addr 3/0x11, mem addr 4/0x22) → mem accepted first (alu_ready=0); write port shows 4/0x22, then 3/0x11.
- wb_stall=1; push 4 writes to regs 1..4 → fifo_count=4, both ready low, pending_mask=0x1E, reg_we=0; release stall → four consecutive writes in order 1,2,3,4.
- mem_valid, addr=0, data=0xFFFFFFFF → mem_ready=1, fifo_count stays 0, reg_we never asserts.
- Fill to 3 entries, pull rst low mid-stream → fifo_count=0, reg_we=0 immediately (asynchronously); after release no stale writes appear.
- With WB_BYPASS_EN: empty FIFO, alu addr 7/0x55 → reg_we=1 with 7/0x55 in the same cycle, fifo_count stays 0.
